// File: rtl/alib_ri_pkg.sv
// Shared definitions for the range-image store: FSM state encoding, empty-range marker, default widths.
package alib_ri_pkg;

    localparam int RI_ADDR_W   = 19;
    localparam int RI_DATA_W   = 16;
    localparam int EMPTY_RANGE = 0;

    typedef enum logic [1:0] {
        ST_CLEAR,
        ST_ACCUM,
        ST_DRAIN,
        ST_HOLD
    } ri_state_e;

endpackage

// File: rtl/ri_sdp_bram.sv
// Simple dual-port BRAM: one write port, one read port with a 1-cycle registered, read-first output.
module ri_sdp_bram #(
    parameter int ADDR_W = 19,
    parameter int DATA_W = 16,
    parameter int DEPTH  = 2**ADDR_W
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // NOTE: neither the array nor its read register is reset; the CLEAR sweep
    // initialises contents, and a reset here would prevent block-RAM mapping.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
        rdata_q <= mem[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/range_image_store.sv
// Nearest-return range-image buffer: clear sweep, read-modify-write accumulation, drain, frozen host readout.
// Optional statistics counters are built when RI_STORE_STATS_EN is defined.
module range_image_store
    import alib_ri_pkg::*;
#(
    parameter int ADDR_W = RI_ADDR_W,
    parameter int DATA_W = RI_DATA_W,
    parameter int DEPTH  = 2**ADDR_W
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_wr,
    input  logic [ADDR_W-1:0] i_wAddress,
    input  logic [DATA_W-1:0] i_range,
    input  logic              i_frame_done,
    input  logic              i_rd_en,
    input  logic [ADDR_W-1:0] i_rd_addr,
    input  logic              i_rd_done,
    output logic [DATA_W-1:0] o_rd_data,
    output logic              o_rd_valid,
    output logic              o_frame_ready,
    output logic              o_busy,
    output logic [31:0]       o_drop_cnt,
    output logic [31:0]       o_upd_cnt
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_X   = (ADDR_W + 1)'(DEPTH);
    localparam logic [DATA_W-1:0] EMPTY     = DATA_W'(EMPTY_RANGE);

    ri_state_e         state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              busy_q, rd_valid_q;
    logic              s1_valid_q, wb_valid_q;
    logic [ADDR_W-1:0] s1_addr_q, wb_addr_q;
    logic [DATA_W-1:0] s1_range_q, wb_data_q;

    logic              wr_nz, addr_ok, accept;
    logic [DATA_W-1:0] bram_rdata, stored, merged;
    logic              replace;
    logic              bram_we;
    logic [ADDR_W-1:0] bram_waddr, bram_raddr;
    logic [DATA_W-1:0] bram_wdata;

    assign wr_nz   = i_wr && (i_range != EMPTY);
    assign addr_ok = {1'b0, i_wAddress} < DEPTH_X;
    assign accept  = (state_q == ST_ACCUM) && wr_nz && addr_ok;

    // The memory is read-first, so a merge committed in the same cycle as the
    // next read of that pixel must be forwarded from the write-back register.
    always_comb begin
        stored  = (wb_valid_q && (wb_addr_q == s1_addr_q)) ? wb_data_q : bram_rdata;
        replace = s1_valid_q && ((stored == EMPTY) || (s1_range_q < stored));
        merged  = replace ? s1_range_q : stored;
    end

    // NOTE: every output of this block gets a default first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        unique case (state_q)
            ST_CLEAR: if (cnt_q == LAST_ADDR) state_d = ST_ACCUM;
            ST_ACCUM: begin
                cnt_d = '0;
                if (i_frame_done) state_d = ST_DRAIN;
            end
            ST_DRAIN: if (cnt_q == ADDR_W'(1)) state_d = ST_HOLD;
            ST_HOLD: begin
                cnt_d = '0;
                if (i_rd_done) state_d = ST_CLEAR;
            end
            default: state_d = ST_CLEAR;
        endcase
    end

    always_comb begin
        bram_we    = (state_q == ST_CLEAR) ? 1'b1  : replace;
        bram_waddr = (state_q == ST_CLEAR) ? cnt_q : s1_addr_q;
        bram_wdata = (state_q == ST_CLEAR) ? EMPTY : s1_range_q;
        bram_raddr = (state_q == ST_HOLD)  ? i_rd_addr : i_wAddress;
    end

    ri_sdp_bram #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_bram (
        .clk_i   (i_clk),
        .we_i    (bram_we),
        .waddr_i (bram_waddr),
        .wdata_i (bram_wdata),
        .raddr_i (bram_raddr),
        .rdata_o (bram_rdata)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= ST_CLEAR;
            cnt_q      <= '0;
            busy_q     <= 1'b1;
            rd_valid_q <= 1'b0;
            s1_valid_q <= 1'b0;
            wb_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            busy_q     <= (state_d == ST_CLEAR) || (state_d == ST_DRAIN);
            rd_valid_q <= (state_q == ST_HOLD) && i_rd_en;
            s1_valid_q <= accept;
            wb_valid_q <= s1_valid_q;
        end
    end

    // Payload registers are qualified by the valids above and need no reset.
    always_ff @(posedge i_clk) begin
        s1_addr_q  <= i_wAddress;
        s1_range_q <= i_range;
        wb_addr_q  <= s1_addr_q;
        wb_data_q  <= merged;
    end

    assign o_rd_data     = rd_valid_q ? bram_rdata : '0;
    assign o_rd_valid    = rd_valid_q;
    assign o_frame_ready = (state_q == ST_HOLD);
    assign o_busy        = busy_q;

`ifdef RI_STORE_STATS_EN
    logic [31:0] drop_q, upd_q;
    logic        drop;

    assign drop = wr_nz && !accept;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            drop_q <= '0;
            upd_q  <= '0;
        end else begin
            if (drop && (drop_q != '1)) drop_q <= drop_q + 1'b1;
            if ((state_q != ST_CLEAR) && (state_d == ST_CLEAR)) upd_q <= '0;
            else if (replace)                                   upd_q <= upd_q + 1'b1;
        end
    end

    assign o_drop_cnt = drop_q;
    assign o_upd_cnt  = upd_q;
`else
    assign o_drop_cnt = '0;
    assign o_upd_cnt  = '0;
`endif

endmodule

// File: tb/tb_range_image_store.sv
// Self-checking bench for range_image_store (DEPTH=16): directed frames plus randomized writes against a per-pixel model.
module tb_range_image_store;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 16;
    localparam int DEPTH  = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              wr;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] range_in;
    logic              frame_done;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_done;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              frame_ready;
    logic              busy;
    logic [31:0]       drop_cnt;
    logic [31:0]       upd_cnt;

    int checks = 0;
    int errors = 0;

    // Reference: nearest return per pixel, plus event counts.
    int ref_mem [DEPTH];
    int ref_drop;
    int ref_upd;
    bit in_accum;

    always #5 clk = ~clk;

    range_image_store #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_wr          (wr),
        .i_wAddress    (w_addr),
        .i_range       (range_in),
        .i_frame_done  (frame_done),
        .i_rd_en       (rd_en),
        .i_rd_addr     (rd_addr),
        .i_rd_done     (rd_done),
        .o_rd_data     (rd_data),
        .o_rd_valid    (rd_valid),
        .o_frame_ready (frame_ready),
        .o_busy        (busy),
        .o_drop_cnt    (drop_cnt),
        .o_upd_cnt     (upd_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_stat(input int v);
`ifdef RI_STORE_STATS_EN
        return 32'(v);
`else
        return (v == v) ? 32'd0 : 32'd1;
`endif
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        foreach (ref_mem[i]) ref_mem[i] = 0;
        ref_upd  = 0;
        in_accum = 0;
    endtask

    // One input cycle; the model applies the nearest-return rule to each write.
    task automatic drive(input bit w, input int addr, input int rng, input bit fd);
        wr         = w;
        w_addr     = ADDR_W'(addr);
        range_in   = DATA_W'(rng);
        frame_done = fd;
        if (w && rng != 0) begin
            if (in_accum && addr < DEPTH) begin
                if (ref_mem[addr] == 0 || rng < ref_mem[addr]) begin
                    ref_mem[addr] = rng;
                    ref_upd++;
                end
            end else begin
                ref_drop++;
            end
        end
        step();
        wr         = 1'b0;
        frame_done = 1'b0;
        if (fd && in_accum) in_accum = 0;
    endtask

    task automatic wait_clear(input string tag);
        int n = 0;
        while (busy && n < 40) begin
            n++;
            step();
        end
        check({tag, "_clear_cycles"}, 32'(n), 32'd16);
        check({tag, "_ready_after_clear"}, 32'(frame_ready), 32'd0);
        in_accum = 1;
    endtask

    task automatic apply_reset(input string tag);
        rst = 1'b1;
        step();
        step();
        check({tag, "_rst_busy"},     32'(busy),        32'd1);
        check({tag, "_rst_ready"},    32'(frame_ready), 32'd0);
        check({tag, "_rst_rd_valid"}, 32'(rd_valid),    32'd0);
        check({tag, "_rst_rd_data"},  32'(rd_data),     32'd0);
        check({tag, "_rst_drop"},     drop_cnt,         32'd0);
        check({tag, "_rst_upd"},      upd_cnt,          32'd0);
        rst = 1'b0;
        model_clear();
        ref_drop = 0;
        wait_clear(tag);
    endtask

    task automatic end_frame(input string tag, input bit w, input int addr, input int rng);
        int n  = 0;
        int nb = 0;
        drive(w, addr, rng, 1'b1);
        while (!frame_ready && n < 20) begin
            if (busy) nb++;
            n++;
            step();
        end
        check({tag, "_drain_busy"}, 32'(nb), 32'd2);
        check({tag, "_hold_ready"}, 32'(frame_ready), 32'd1);
        check({tag, "_hold_busy"},  32'(busy), 32'd0);
    endtask

    task automatic read_all(input string tag);
        for (int a = 0; a < DEPTH; a++) begin
            rd_en   = 1'b1;
            rd_addr = ADDR_W'(a);
            step();
            check($sformatf("%s_rd_valid_%0d", tag, a), 32'(rd_valid), 32'd1);
            check($sformatf("%s_rd_data_%0d", tag, a), 32'(rd_data), 32'(ref_mem[a]));
        end
        rd_en = 1'b0;
        step();
        check({tag, "_rd_valid_end"}, 32'(rd_valid), 32'd0);
    endtask

    task automatic next_frame(input string tag);
        rd_done = 1'b1;
        step();
        rd_done = 1'b0;
        model_clear();
        wait_clear(tag);
        check({tag, "_upd_zeroed"}, upd_cnt, exp_stat(ref_upd));
    endtask

    task automatic random_writes(input int count);
        for (int i = 0; i < count; i++) begin
            int addr = ($urandom_range(0, 1) == 1) ? int'($urandom_range(4, 6)) : int'($urandom_range(0, 19));
            int rng  = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 1000));
            drive(1'b1, addr, rng, 1'b0);
            repeat ($urandom_range(0, 2)) step();
        end
        step();
        step();
    endtask

    initial begin
        rst        = 1'b1;
        wr         = 1'b0;
        w_addr     = '0;
        range_in   = '0;
        frame_done = 1'b0;
        rd_en      = 1'b0;
        rd_addr    = '0;
        rd_done    = 1'b0;
        ref_drop   = 0;
        model_clear();

        // Frame 1: empty image after the initial clear.
        apply_reset("f1");
        end_frame("f1", 1'b0, 0, 0);
        read_all("f1");
        next_frame("f1");

        // Frame 2: directed merges, forwarding, drops, then random traffic.
        drive(1'b1, 3, 500, 1'b0); step(); step();
        drive(1'b1, 3, 300, 1'b0); step(); step();
        drive(1'b1, 3, 400, 1'b0); step(); step();
        check("f2_upd_addr3", upd_cnt, exp_stat(ref_upd));
        drive(1'b1, 5, 900, 1'b0);
        drive(1'b1, 5, 200, 1'b0);
        drive(1'b1, 5, 700, 1'b0);
        drive(1'b1, 2, 0, 1'b0);
        drive(1'b1, 20, 100, 1'b0);
        step(); step();
        check("f2_drop_addr20", drop_cnt, exp_stat(ref_drop));
        check("f2_upd_directed", upd_cnt, exp_stat(ref_upd));
        rd_en   = 1'b1;
        rd_addr = ADDR_W'(3);
        step();
        rd_en = 1'b0;
        check("f2_rd_in_accum_valid", 32'(rd_valid), 32'd0);
        check("f2_rd_in_accum_data", 32'(rd_data), 32'd0);
        random_writes(40);
        check("f2_drop_random", drop_cnt, exp_stat(ref_drop));
        check("f2_upd_random", upd_cnt, exp_stat(ref_upd));
        end_frame("f2", 1'b1, 9, 77);
        drive(1'b1, 7, 50, 1'b0);
        check("f2_drop_hold", drop_cnt, exp_stat(ref_drop));
        read_all("f2");
        check("f2_upd_final", upd_cnt, exp_stat(ref_upd));
        next_frame("f2");

        // Frame 3: random traffic over a freshly cleared image.
        random_writes(40);
        end_frame("f3", 1'b1, 4, 1);
        read_all("f3");
        check("f3_drop", drop_cnt, exp_stat(ref_drop));
        check("f3_upd", upd_cnt, exp_stat(ref_upd));

        // Reset while the clear sweep is at pixel 9.
        rd_done = 1'b1;
        step();
        rd_done = 1'b0;
        repeat (9) step();
        check("f4_busy_mid_clear", 32'(busy), 32'd1);
        apply_reset("f4");
        end_frame("f4", 1'b0, 0, 0);
        read_all("f4");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
